// File: rtl/game_state_ctrl.sv
// game_state_ctrl: pong match controller that sequences serve, rally and match end,
// detects missed balls from ball_x, keeps both scores and declares the winner.
`default_nettype none

module game_state_ctrl #(
  parameter logic [9:0] MISS_LEFT_X  = 10'd140,
  parameter logic [9:0] MISS_RIGHT_X = 10'd500,
  parameter logic [9:0] BALL_WIDTH   = 10'd5,
  parameter logic [3:0] WIN_SCORE    = 4'd5,
  parameter logic [7:0] SERVE_HOLD   = 8'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1u,
  input  logic       p1d,
  input  logic       p2u,
  input  logic       p2d,
  input  logic [9:0] ball_x,
  output logic [1:0] game_state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic       point
);

  typedef enum logic [1:0] {
    P1_SERVE = 2'd0,
    P2_SERVE = 2'd1,
    PLAYING  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  p1_score_q;
  logic [3:0]  p2_score_q;
  logic [1:0]  winner_q;
  logic        point_q;
  logic [7:0]  hold_cnt_q;
  logic [3:0]  btn_prev_q;
  logic        rearm_q;

  logic [3:0]  btn;
  logic [3:0]  press;
  logic        serve_ok;
  logic        serve_press;
  logic [7:0]  hold_cnt_d;
  logic [9:0]  ball_right;
  logic        miss_left;
  logic        miss_right;
  logic [3:0]  p1_score_d;
  logic [3:0]  p2_score_d;

  // Button bit order: {p2d, p2u, p1d, p1u}; buttons are active-low.
  assign btn         = {p2d, p2u, p1d, p1u};
  assign press       = btn_prev_q & ~btn;
  assign serve_ok    = (hold_cnt_q == SERVE_HOLD);
  assign serve_press = (state_q == P1_SERVE) ? |press[1:0] : |press[3:2];
  assign hold_cnt_d  = serve_ok ? hold_cnt_q : hold_cnt_q + 8'd1;

  assign ball_right  = ball_x + BALL_WIDTH;
  assign miss_left   = (ball_x < MISS_LEFT_X);
  assign miss_right  = (ball_right > MISS_RIGHT_X);
  assign p1_score_d  = (p1_score_q < WIN_SCORE) ? p1_score_q + 4'd1 : p1_score_q;
  assign p2_score_d  = (p2_score_q < WIN_SCORE) ? p2_score_q + 4'd1 : p2_score_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= P1_SERVE;
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
      winner_q   <= 2'd0;
      point_q    <= 1'b0;
      hold_cnt_q <= 8'd0;
      btn_prev_q <= 4'hF;
      rearm_q    <= 1'b0;
    end else begin
      btn_prev_q <= btn;
      point_q    <= 1'b0;
      case (state_q)
        P1_SERVE, P2_SERVE: begin
          if (serve_ok && serve_press) begin
            state_q <= PLAYING;
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        PLAYING: begin
          if (miss_left) begin
            point_q    <= 1'b1;
            hold_cnt_q <= 8'd0;
            p2_score_q <= p2_score_d;
            if (p2_score_q + 4'd1 == WIN_SCORE) begin
              state_q  <= DONE;
              winner_q <= 2'd2;
              rearm_q  <= 1'b0;
            end else begin
              state_q  <= P1_SERVE;
            end
          end else if (miss_right) begin
            point_q    <= 1'b1;
            hold_cnt_q <= 8'd0;
            p1_score_q <= p1_score_d;
            if (p1_score_q + 4'd1 == WIN_SCORE) begin
              state_q  <= DONE;
              winner_q <= 2'd1;
              rearm_q  <= 1'b0;
            end else begin
              state_q  <= P2_SERVE;
            end
          end
        end
        default: begin
          // A restart needs one fully released tick first, so a held button cannot skip the end screen.
          if (rearm_q && |press) begin
            state_q    <= P1_SERVE;
            p1_score_q <= 4'd0;
            p2_score_q <= 4'd0;
            winner_q   <= 2'd0;
            hold_cnt_q <= 8'd0;
            rearm_q    <= 1'b0;
          end else if (&btn) begin
            rearm_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign game_state = state_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign winner     = winner_q;
  assign point      = point_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: scoreboard bench for game_state_ctrl covering serve hold,
// misses at both edges, winning for each player, rearm in done and async reset.
`default_nettype none

module tb_game_state_ctrl;

  localparam logic [1:0] S_P1  = 2'd0;
  localparam logic [1:0] S_P2  = 2'd1;
  localparam logic [1:0] S_PLY = 2'd2;
  localparam logic [1:0] S_DN  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       p1u, p1d, p2u, p2d;
  logic [9:0] ball_x;
  logic [1:0] game_state;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;
  logic       point;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] w;
    logic       pt;
  } exp_t;

  exp_t sb[$];
  logic [1:0] e_st;
  logic [3:0] e1, e2;
  logic [1:0] e_w;
  int n_chk = 0;
  int n_fail = 0;

  game_state_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .p1u        (p1u),
    .p1d        (p1d),
    .p2u        (p2u),
    .p2d        (p2d),
    .ball_x     (ball_x),
    .game_state (game_state),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .winner     (winner),
    .point      (point)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one tick; the expectation for the following edge is queued, then retired after it.
  task automatic tick(input logic [3:0] b, input logic [9:0] x, input logic pt);
    exp_t e;
    exp_t g;
    @(negedge clk);
    {p2d, p2u, p1d, p1u} = b;
    ball_x = x;
    e = '{st: e_st, p1: e1, p2: e2, w: e_w, pt: pt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      g = sb.pop_front();
      check("state",    16'(game_state), 16'(g.st));
      check("p1_score", 16'(p1_score),   16'(g.p1));
      check("p2_score", 16'(p2_score),   16'(g.p2));
      check("winner",   16'(winner),     16'(g.w));
      check("point",    16'(point),      16'(g.pt));
    end
  endtask

  // Serve hold is 30 ticks: a press on tick 30 is too early, tick 31 is a
  // press by the other player (ignored), tick 32 is the accepted serve.
  task automatic serve(input logic [3:0] smask, input logic [3:0] omask);
    logic [9:0] x;
    for (int j = 1; j <= 29; j++) begin
      x = (j % 3 == 0) ? 10'd500 : ((j % 3 == 1) ? 10'd100 : 10'd300);
      tick(4'hF, x, 1'b0);
    end
    tick(~smask, 10'd300, 1'b0);
    tick(~omask, 10'd500, 1'b0);
    e_st = S_PLY;
    tick(~smask, 10'd300, 1'b0);
  endtask

  task automatic miss(input logic [9:0] x);
    if (x < 10'd140) begin
      e2 = e2 + 4'd1;
      if (e2 == 4'd5) begin e_st = S_DN; e_w = 2'd2; end
      else e_st = S_P1;
    end else begin
      e1 = e1 + 4'd1;
      if (e1 == 4'd5) begin e_st = S_DN; e_w = 2'd1; end
      else e_st = S_P2;
    end
    tick(4'hF, x, 1'b1);
  endtask

  task automatic serve_current();
    if (e_st == S_P1) serve(4'b0001, 4'b0100);
    else              serve(4'b1000, 4'b0001);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 16'(game_state), 16'(S_P1));
    check({tag, "_p1"},    16'(p1_score),   16'd0);
    check({tag, "_p2"},    16'(p2_score),   16'd0);
    check({tag, "_win"},   16'(winner),     16'd0);
    check({tag, "_point"}, 16'(point),      16'd0);
  endtask

  initial begin
    reset = 1'b0;
    {p2d, p2u, p1d, p1u} = 4'hF;
    ball_x = 10'd300;
    e_st = S_P1; e1 = 4'd0; e2 = 4'd0; e_w = 2'd0;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #2 reset = 1'b1;

    serve(4'b0001, 4'b0100);
    tick(4'b0000, 10'd300, 1'b0);
    tick(4'hF, 10'd140, 1'b0);
    tick(4'hF, 10'd495, 1'b0);
    tick(4'hF, 10'd1023, 1'b0);
    miss(10'd139);

    serve(4'b0011, 4'b1100);
    miss(10'd496);
    serve(4'b0100, 4'b0001);
    miss(10'd0);
    serve(4'b0001, 4'b0100);
    miss(10'd496);
    serve(4'b1000, 4'b0010);
    miss(10'd496);
    serve(4'b0100, 4'b0001);
    tick(4'hF, 10'd300, 1'b0);

    // Asynchronous reset in the middle of a 3/2 rally.
    @(negedge clk); #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #2;
    check("rst_held_state", 16'(game_state), 16'(S_P1));
    reset = 1'b1;
    e_st = S_P1; e1 = 4'd0; e2 = 4'd0; e_w = 2'd0;

    for (int i = 0; i < 4; i++) begin
      serve_current();
      miss(10'd600);
    end
    serve_current();
    e1 = 4'd5; e_st = S_DN; e_w = 2'd1;
    tick(4'b1110, 10'd600, 1'b1);
    tick(4'b1110, 10'd100, 1'b0);
    tick(4'hF, 10'd100, 1'b0);
    e_st = S_P1; e1 = 4'd0; e2 = 4'd0; e_w = 2'd0;
    tick(4'b0111, 10'd300, 1'b0);

    for (int i = 0; i < 5; i++) begin
      serve_current();
      miss(10'd0);
    end
    tick(4'b1101, 10'd0, 1'b0);
    tick(4'hF, 10'd600, 1'b0);
    e_st = S_P1; e1 = 4'd0; e2 = 4'd0; e_w = 2'd0;
    tick(4'b1110, 10'd300, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
